// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit:
// access size encodings, FSM states and default memory size.
package lsu_pkg;

  localparam int unsigned LSU_DMEM_BYTES = 256;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    LD_RD,
    ST_RMW_RD,
    ST_WR,
    RESP
  } lsu_state_e;

endpackage

// File: rtl/load_store_unit_lane_align.sv
// Little-endian lane extraction/extension for loads and
// lane merge for sub-word stores.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic        uns,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] ld_data,
  output logic [31:0] st_word
);

  logic [31:0] shifted;
  logic [7:0]  b;
  logic [15:0] h;

  // pick the addressed lane and extend it
  always_comb begin
    shifted = word >> {offset, 3'b000};
    b       = shifted[7:0];
    h       = offset[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: ld_data = uns ? {24'h0, b} : {{24{b[7]}}, b};
      SZ_HALF: ld_data = uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: ld_data = word;
    endcase
  end

  // replace the addressed lane with right-aligned store data
  always_comb begin
    st_word = word;
    case (size)
      SZ_BYTE: st_word[{offset, 3'b000} +: 8] = wdata[7:0];
      SZ_HALF: begin
        if (offset[1]) st_word[31:16] = wdata[15:0];
        else           st_word[15:0]  = wdata[15:0];
      end
      default: st_word = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between MEM stage and data memory:
// sub-word stores by read-modify-write, extended loads.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned DMEM_BYTES = LSU_DMEM_BYTES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_load,
  input  logic        req_store,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic [31:0] mem_addr,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  lsu_state_e  state, state_nxt;
  logic        uns_q, err_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q, rdata_q, wword_q;
  logic        req_err, accept;
  logic [31:0] ld_data, st_word;

  // classify the incoming request as illegal
  always_comb begin
    req_err = (req_load == req_store)
           || (req_size == 2'b11)
           || (req_size == SZ_HALF && req_addr[0])
           || (req_size == SZ_WORD && req_addr[1:0] != 2'b00)
           || (req_addr >= DMEM_BYTES);
  end

  assign accept = (state == IDLE) && req_valid;

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // next state and memory/response strobes
  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    resp_valid = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = !reset;
        if (req_valid) begin
          if (req_err)                 state_nxt = RESP;
          else if (req_load)           state_nxt = LD_RD;
          else if (req_size == SZ_WORD) state_nxt = ST_WR;
          else                         state_nxt = ST_RMW_RD;
        end
      end
      LD_RD: begin
        mem_read  = 1'b1;
        state_nxt = RESP;
      end
      ST_RMW_RD: begin
        mem_read  = 1'b1;
        state_nxt = ST_WR;
      end
      ST_WR: begin
        mem_write = 1'b1;
        state_nxt = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // latch request fields, load result and store word
  always_ff @(posedge clk) begin
    if (reset) begin
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      wword_q <= '0;
    end else begin
      if (accept) begin
        uns_q   <= req_unsigned;
        err_q   <= req_err;
        size_q  <= req_size;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        wword_q <= req_wdata;
        rdata_q <= '0;
      end
      if (state == LD_RD)     rdata_q <= ld_data;
      if (state == ST_RMW_RD) wword_q <= st_word;
    end
  end

  lsu_lane_align u_align (
    .size    (size_q),
    .offset  (addr_q[1:0]),
    .uns     (uns_q),
    .word    (mem_rdata),
    .wdata   (wdata_q),
    .ld_data (ld_data),
    .st_word (st_word)
  );

  assign mem_addr   = {addr_q[31:2], 2'b00};
  assign mem_wdata  = wword_q;
  assign resp_err   = (state == RESP) && err_q;
  assign resp_rdata = (state == RESP) ? rdata_q : 32'h0;

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: word-array memory
// model and a response scoreboard.
module tb_load_store_unit;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_load;
  logic        req_store;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_addr;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int tests = 0;
  int fails = 0;
  int strobes = 0;
  int writes = 0;
  int resp_cnt = 0;

  logic [32:0] exp_q[$];
  logic [31:0] mem [64];

  load_store_unit dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_load     (req_load),
    .req_store    (req_store),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_err     (resp_err),
    .resp_rdata   (resp_rdata),
    .mem_addr     (mem_addr),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[7:2]];

  // data memory write port
  always @(posedge clk) begin
    if (mem_write) mem[mem_addr[7:2]] = mem_wdata;
  end

  // strobe monitor and response scoreboard
  always @(negedge clk) begin
    logic [32:0] e;
    tests++;
    if (mem_read && mem_write) begin
      fails++;
      $display("FAIL strobe_overlap: read=%b write=%b, need not both",
               mem_read, mem_write);
    end
    if (mem_read || mem_write) strobes++;
    if (mem_write) writes++;
    if (resp_valid) begin
      resp_cnt++;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected: err=%b rdata=%h, none expected",
                 resp_err, resp_rdata);
      end else begin
        e = exp_q.pop_front();
        if ({resp_err, resp_rdata} !== e) begin
          fails++;
          $display("FAIL sb_resp: got err=%b rdata=%h, need err=%b rdata=%h",
                   resp_err, resp_rdata, e[32], e[31:0]);
        end
      end
    end
  end

  task automatic drive(input logic ld, input logic st,
                       input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd);
    req_load     = ld;
    req_store    = st;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = a;
    req_wdata    = wd;
    req_valid    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid    = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if (req_ready !== 1'b0) begin
      fails++;
      $display("FAIL reset_ready_low: got %b need 0", req_ready);
    end
    reset = 1'b0;
    @(negedge clk);
    tests++;
    if (req_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready: got %b need 1", req_ready);
    end
    tests++;
    if ({resp_valid, resp_err, mem_read, mem_write} !== 4'b0 ||
        resp_rdata !== 32'h0 || mem_wdata !== 32'h0 ||
        mem_addr !== 32'h0) begin
      fails++;
      $display("FAIL reset_outputs: rv=%b re=%b rd=%b wr=%b rdata=%h wdata=%h addr=%h, need all 0",
               resp_valid, resp_err, mem_read, mem_write,
               resp_rdata, mem_wdata, mem_addr);
    end
  endtask

  task automatic do_load(input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] exp);
    exp_q.push_back({1'b0, exp});
    drive(1'b1, 1'b0, sz, uns, a, 32'h0);
    tests++;
    if (mem_read !== 1'b1 || mem_write !== 1'b0 ||
        mem_addr !== {a[31:2], 2'b00}) begin
      fails++;
      $display("FAIL ld_cycle1 @%h: rd=%b wr=%b addr=%h, need 1 0 %h",
               a, mem_read, mem_write, mem_addr, {a[31:2], 2'b00});
    end
    @(negedge clk);
    tests++;
    if (resp_valid !== 1'b1) begin
      fails++;
      $display("FAIL ld_resp_cycle2 @%h: resp_valid=%b need 1", a, resp_valid);
    end
    @(negedge clk);
    tests++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      fails++;
      $display("FAIL ld_cycle3 @%h: rv=%b ready=%b, need 0 1",
               a, resp_valid, req_ready);
    end
  endtask

  task automatic test_loads();
    do_load(2'b10, 1'b0, 32'h1C, 32'h76840077);
    do_load(2'b00, 1'b0, 32'h03, 32'hFFFFFFA0);
    do_load(2'b00, 1'b1, 32'h03, 32'h000000A0);
    do_load(2'b01, 1'b0, 32'h02, 32'hFFFFA011);
    do_load(2'b01, 1'b1, 32'h00, 32'h000000AB);
  endtask

  task automatic test_back_to_back();
    int cyc = 0;
    int t1 = -1;
    int t2 = -1;
    int r0 = resp_cnt;
    exp_q.push_back({1'b0, 32'h10101011});
    exp_q.push_back({1'b0, 32'h21101122});
    req_load     = 1'b1;
    req_store    = 1'b0;
    req_size     = 2'b10;
    req_unsigned = 1'b0;
    req_addr     = 32'h04;
    req_wdata    = 32'h0;
    req_valid    = 1'b1;
    for (int i = 0; i < 12 && t2 < 0; i++) begin
      if (req_ready) begin
        if (t1 < 0) t1 = cyc;
        else        t2 = cyc;
        @(negedge clk);
        cyc++;
        if (t2 < 0) req_addr = 32'h08;
        else        req_valid = 1'b0;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (t1 < 0 || t2 < 0 || t2 - t1 != 3) begin
      fails++;
      $display("FAIL b2b_spacing: first=%0d second=%0d, need gap 3", t1, t2);
    end
    tests++;
    if (resp_cnt - r0 != 2) begin
      fails++;
      $display("FAIL b2b_pulses: got %0d response cycles, need 2",
               resp_cnt - r0);
    end
  endtask

  task automatic test_sub_word_store();
    exp_q.push_back({1'b0, 32'h0});
    drive(1'b0, 1'b1, 2'b00, 1'b0, 32'h09, 32'h0000005A);
    tests++;
    if (mem_read !== 1'b1 || mem_write !== 1'b0) begin
      fails++;
      $display("FAIL sb_cycle1: rd=%b wr=%b, need 1 0", mem_read, mem_write);
    end
    @(negedge clk);
    tests++;
    if (mem_write !== 1'b1 || mem_read !== 1'b0 ||
        mem_addr !== 32'h08 || mem_wdata !== 32'h21105A22) begin
      fails++;
      $display("FAIL sb_cycle2: wr=%b rd=%b addr=%h wdata=%h, need 1 0 00000008 21105a22",
               mem_write, mem_read, mem_addr, mem_wdata);
    end
    @(negedge clk);
    tests++;
    if (resp_valid !== 1'b1) begin
      fails++;
      $display("FAIL sb_resp_cycle3: resp_valid=%b need 1", resp_valid);
    end
    @(negedge clk);
    do_load(2'b10, 1'b0, 32'h08, 32'h21105A22);
  endtask

  task automatic test_word_store();
    exp_q.push_back({1'b0, 32'h0});
    drive(1'b0, 1'b1, 2'b10, 1'b0, 32'hFC, 32'hCAFEF00D);
    tests++;
    if (mem_write !== 1'b1 || mem_read !== 1'b0 ||
        mem_addr !== 32'hFC || mem_wdata !== 32'hCAFEF00D) begin
      fails++;
      $display("FAIL sw_cycle1: wr=%b rd=%b addr=%h wdata=%h, need 1 0 000000fc cafef00d",
               mem_write, mem_read, mem_addr, mem_wdata);
    end
    @(negedge clk);
    tests++;
    if (resp_valid !== 1'b1) begin
      fails++;
      $display("FAIL sw_resp_cycle2: resp_valid=%b need 1", resp_valid);
    end
    @(negedge clk);
    do_load(2'b01, 1'b1, 32'hFE, 32'h0000CAFE);
    do_load(2'b01, 1'b0, 32'hFE, 32'hFFFFCAFE);
    do_load(2'b00, 1'b0, 32'hFD, 32'hFFFFFFF0);
  endtask

  task automatic do_error(input logic ld, input logic st,
                          input logic [1:0] sz, input logic [31:0] a);
    int s0 = strobes;
    exp_q.push_back({1'b1, 32'h0});
    drive(ld, st, sz, 1'b0, a, 32'h12345678);
    tests++;
    if (resp_valid !== 1'b1 || resp_err !== 1'b1) begin
      fails++;
      $display("FAIL err_cycle1 @%h: rv=%b err=%b, need 1 1",
               a, resp_valid, resp_err);
    end
    repeat (2) @(negedge clk);
    tests++;
    if (strobes != s0) begin
      fails++;
      $display("FAIL err_strobe @%h: %0d memory strobes, need 0",
               a, strobes - s0);
    end
  endtask

  task automatic test_errors();
    do_error(1'b1, 1'b0, 2'b01, 32'h005);
    do_error(1'b1, 1'b0, 2'b10, 32'h102);
    do_error(1'b0, 1'b1, 2'b10, 32'h100);
    do_error(1'b1, 1'b1, 2'b10, 32'h000);
  endtask

  task automatic test_reset_mid_rmw();
    int w0;
    drive(1'b0, 1'b1, 2'b01, 1'b0, 32'h10, 32'h0000BEEF);
    w0 = writes;
    tests++;
    if (mem_read !== 1'b1) begin
      fails++;
      $display("FAIL rst_rmw_read: rd=%b need 1", mem_read);
    end
    reset = 1'b1;
    @(negedge clk);
    tests++;
    if (mem_write !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b0) begin
      fails++;
      $display("FAIL rst_rmw_abort: wr=%b rv=%b ready=%b, need 0 0 0",
               mem_write, resp_valid, req_ready);
    end
    reset = 1'b0;
    @(negedge clk);
    tests++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      fails++;
      $display("FAIL rst_rmw_ready: ready=%b rv=%b, need 1 0",
               req_ready, resp_valid);
    end
    @(negedge clk);
    tests++;
    if (writes != w0 || mem[4] !== 32'h42270044) begin
      fails++;
      $display("FAIL rst_rmw_mem: writes=%0d word=%h, need 0 42270044",
               writes - w0, mem[4]);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[0]         = 32'hA01100AB;
    mem[1]         = 32'h10101011;
    mem[2]         = 32'h21101122;
    mem[4]         = 32'h42270044;
    mem[32'h1C/4]  = 32'h76840077;
    req_valid    = 1'b0;
    req_load     = 1'b0;
    req_store    = 1'b0;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    req_addr     = 32'h0;
    req_wdata    = 32'h0;
    reset        = 1'b1;
    @(negedge clk);
    test_reset();
    test_loads();
    test_back_to_back();
    test_sub_word_store();
    test_word_store();
    test_errors();
    test_reset_mid_rmw();
    repeat (2) @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL sb_drain: %0d responses missing, need 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Load/store unit between the MEM pipeline stage and `dataMemory`. It accepts one memory request per transaction from the pipeline, performs sub-word stores as read-modify-write, and extracts and sign- or zero-extends loaded bytes and halfwords. It also rejects misaligned and out-of-range accesses. It drives `dataMemory`'s word-aligned byte address, `MemRead`, `MemWrite` and `data_input`, and consumes its `data_Out`.

## Interface
- `DMEM_BYTES`, 256: addressable bytes in data memory. Highest legal word address is `DMEM_BYTES-4`.
- `clk` in 1: the single clock.
- `reset` in 1: reset, synchronous and active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit can accept a request.
- `req_load` in 1: request is a load.
- `req_store` in 1: request is a store.
- `req_size` in 2: access size. 00 = byte, 01 = half, 10 = word, 11 = illegal.
- `req_unsigned` in 1: zero-extend loads (LBU/LHU).
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-aligned.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_err` out 1: access rejected. Valid with `resp_valid`.
- `resp_rdata` out 32: extended load data. 0 for stores and errors.
- `mem_addr` out 32: word-aligned address, `{req_addr[31:2],2'b00}`.
- `mem_read` out 1: to `MemRead`.
- `mem_write` out 1: to `MemWrite`.
- `mem_wdata` out 32: to `data_input`.
- `mem_rdata` in 32: from `data_Out`. Combinational read.

## Operation
- FSM states: IDLE, LD_RD, ST_RMW_RD, ST_WR, RESP.
- IDLE: `req_ready`=1. On `req_valid`, latch all request fields.
  - Error request: go to RESP with err=1.
  - Load: go to LD_RD.
  - Word store: go to ST_WR.
  - Byte or half store: go to ST_RMW_RD.
- A request is an error if any of these hold:
  - `req_load` and `req_store` are equal (both set or both clear).
  - `req_size`=11.
  - Half with `addr[0]`=1.
  - Word with `addr[1:0]`≠0.
  - `addr` ≥ `DMEM_BYTES`.
- An error request never asserts `mem_read` or `mem_write`.
- LD_RD: `mem_read`=1. Capture lane from `mem_rdata`, little-endian: byte lane k is bits `8k+7:8k`, k=`addr[1:0]`; half lane is `addr[1]`. Extend per `req_unsigned`. Go to RESP.
- ST_RMW_RD: `mem_read`=1. Capture the word, replace the addressed lane with `req_wdata[7:0]` or `req_wdata[15:0]`. Go to ST_WR.
- ST_WR: `mem_write`=1. `mem_wdata` is the merged word, or `req_wdata` for a word store. Go to RESP.
- RESP: `resp_valid`=1 for exactly one cycle. `req_ready`=0. Go to IDLE.
- There is no response backpressure. The consumer must sample `resp_*` in the RESP cycle.
- `mem_read` and `mem_write` are never asserted in the same cycle. `mem_addr` and `mem_wdata` are stable for the whole cycle in which `mem_write`=1.

## Timing
- Cycle 0 is the acceptance edge.
- Load latency: `mem_read` in cycle 1, `resp_valid` in cycle 2.
- Word store latency: `mem_write` in cycle 1, `resp_valid` in cycle 2.
- Sub-word store latency: `mem_read` in cycle 1, `mem_write` in cycle 2, `resp_valid` in cycle 3.
- Error latency: `resp_valid` with `resp_err`=1 in cycle 1.
- `req_ready` returns the cycle after RESP. Peak throughput is one load per 3 cycles.
- `req_ready` is combinational from state and is 0 while `reset`=1.
- Reset values: state IDLE. `resp_valid`, `resp_err`, `resp_rdata`, `mem_read`, `mem_write`, `mem_wdata` and `mem_addr` are all 0.
- Reset mid-transaction:
  - Abort at the next edge with no further memory strobe.
  - The response is dropped.
  - A partially completed RMW never writes.
- `req_valid` held while busy is ignored until `req_ready`=1. Request fields may change freely while not accepted.

## Structure
- Shared `lsu_pkg` holds:
  - Size encodings `SZ_BYTE`, `SZ_HALF`, `SZ_WORD`.
  - FSM state enum.
  - `DMEM_BYTES` default.
- One combinational sub-module, `lsu_lane_align`. Inputs: size, offset, unsigned, word, wdata. Outputs: extended load data and merged store word. It is shared by LD_RD and ST_RMW_RD.

## Test plan
- LW `addr`=0x1C, memory word 0x76840077 → `mem_read` in cycle 1; `resp_valid` in cycle 2 with `resp_rdata`=0x76840077, `resp_err`=0.
- Word at 0x00 = 0xA01100AB:
  - LB 0x03 → 0xFFFFFFA0.
  - LBU 0x03 → 0x000000A0.
  - LH 0x02 → 0xFFFFA011.
  - LHU 0x00 → 0x000000AB.
- SB `wdata`=0x5A at 0x09, word 0x21101122 → read in cycle 1; `mem_write` in cycle 2 with `mem_addr`=0x08, `mem_wdata`=0x21105A22; response in cycle 3. A following LW 0x08 returns 0x21105A22.
- Error cases → `resp_err`=1 in cycle 1, `mem_read` and `mem_write` never high:
  - LH 0x05.
  - LW 0x102.
  - SW 0x100.
  - `req_load`=`req_store`=1.
- `reset` pulsed during ST_RMW_RD of an SH to 0x10 → no `mem_write`, no `resp_valid`. Word 0x10 is unchanged (0x42270044). `req_ready` is 1 the cycle after `reset` falls.
- Back-to-back: `req_valid` held high with LW 0x04 then LW 0x08 → second accepted exactly 3 cycles after the first. Responses return 0x10101011 then 0x21101122, each a single-cycle pulse.
